mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer that shares the single-ported unified memory between instruction fetch (port 0) and load/store (port 1).
- Sits between the processor front-end/LSU and the memory block; drives its rd/wr/addr/data_in and consumes its data_out/write_done/available.
- Sequences each access as a one-transaction-at-a-time handshake, with a completion timeout.

Parameters:
TIMEOUT, 16, cycles to wait for available/write_done before aborting with error; legal range 2..255.

Ports:
clk  input  1  global clock, rising edge
rst_n  input  1  asynchronous active-low reset
p0_req  input  1  port 0 request; held high until p0_done
p0_wr  input  1  port 0: 1 = write, 0 = read
p0_addr  input  32  port 0 address
p0_wdata  input  32  port 0 write data
p0_done  output  1  port 0 one-cycle completion pulse
p0_err  output  1  port 0 timeout flag, valid with p0_done
p0_rdata  output  32  port 0 read data, valid from p0_done until next port 0 read completes
p1_req, p1_wr, p1_addr, p1_wdata, p1_done, p1_err, p1_rdata  same as port 0, for port 1
mem_addr  output  32  to memory addr
mem_data_in  output  32  to memory data_in
mem_wr  output  1  to memory wr
mem_rd  output  1  to memory rd
mem_data_out  input  32  from memory data_out
mem_write_done  input  1  from memory write_done
mem_available  input  1  from memory available
busy  output  1  high whenever state != IDLE
owner  output  1  port currently granted; valid while busy

Behaviour:
- Reset (async, rst_n low): state = IDLE; last = 1 (port 0 wins first tie); cnt = 0; latched addr/wdata/wr/owner = 0; all pN_done, pN_err, pN_rdata = 0; mem_rd = mem_wr = 0; mem_addr = mem_data_in = 0; busy = 0.
- Reset mid-transaction drops the access. A write whose wr edge has already occurred stays committed in memory; no done is ever issued for it.
- States: IDLE, RD, WR, WR_WAIT, RESP.
- IDLE:
  - One requester high: grant it.
  - Both high: grant the port != last.
  - On grant, latch pN_addr, pN_wdata, pN_wr and owner, clear cnt, go to RD (read) or WR (write).
  - No request: stay in IDLE.
- RD: mem_rd = 1, mem_addr = latched addr.
  - mem_available = 1: capture mem_data_out into owner's rdata, go to RESP.
  - Otherwise cnt++. When cnt reaches TIMEOUT-1 without available, go to RESP with err set and rdata unchanged.
- WR: mem_wr = 1 for exactly one cycle, with mem_addr/mem_data_in = latched values; go to WR_WAIT.
- WR_WAIT: mem_wr = 0.
  - mem_write_done = 1: go to RESP.
  - Otherwise count and time out exactly as in RD.
- RESP: owner's pN_done = 1 for one cycle; pN_err = 1 in that cycle only if timed out; last <= owner; go to IDLE. The other port's outputs are untouched.
- mem_rd, mem_wr and busy are decoded from the registered state only; no combinational path from pN_req to memory controls.
- mem_addr/mem_data_in present the latched values in every state.
- Latency from the req-sampling edge:
  - read: RD next cycle, done 2 cycles after the grant edge;
  - write: WR, WR_WAIT, done 3 cycles after.
- Port rules:
  - Fields are sampled only at grant; changes afterwards are ignored.
  - Requester deasserts req in the cycle after done. If req is still high when IDLE is re-entered, it is treated as a new transaction, subject to round-robin.
  - req dropped before grant: no access occurs.
- Fairness: under continuous requests from both ports, grants strictly alternate, 0, 1, 0, 1, ...
- At most one of p0_done/p1_done is high in any cycle.

Test Plan:
- Reset release, p0 read addr 0x10, memory preloaded 0xDEADBEEF -> mem_rd high 1 cycle after grant; p0_done 2 cycles after grant edge; p0_rdata = 0xDEADBEEF; p0_err = 0.
- p1 write addr 0x20 data 0x12345678, then p1 read 0x20 -> mem_wr pulse exactly 1 cycle, p1_done 3 cycles after grant; read returns 0x12345678.
- p0 and p1 read requests asserted in the same cycle from reset -> p0 served first, then p1. Repeat both continuously for 8 transactions -> owner sequence 0,1,0,1,0,1,0,1.
- Force mem_available = 0 (override) during a p1 read, TIMEOUT = 4 -> p1_done with p1_err = 1 after 4 cycles in RD; p1_rdata keeps its previous value; next transaction proceeds normally.
- rst_n pulsed low during WR_WAIT -> mem_wr/mem_rd/busy/done drop asynchronously; state IDLE; no done pulse; next p0 request is granted first.
- p0 changes p0_addr and p0_wdata one cycle after grant -> the memory access uses the originally latched values.

Source files
------------

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arbiter: two-port round-robin sequencer for the unified memory |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_wr,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_done,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_wr,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_done,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_wr,
  output logic        mem_rd,
  input  logic [31:0] mem_data_out,
  input  logic        mem_write_done,
  input  logic        mem_available,
  output logic        busy,
  output logic        owner
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_RD      = 3'd1;
  localparam logic [2:0] c_WR      = 3'd2;
  localparam logic [2:0] c_WR_WAIT = 3'd3;
  localparam logic [2:0] c_RESP    = 3'd4;
  localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  r_state, w_next;
  logic        r_last, r_owner, r_wr, r_err;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr, r_wdata, r_rdata0, r_rdata1;

  logic w_req_any, w_grant, w_gnt_wr, w_timeout;

  // On a tie the port that was not served last wins.
  assign w_req_any = p0_req | p1_req;
  assign w_grant   = (p0_req && p1_req) ? ~r_last : p1_req;
  assign w_gnt_wr  = w_grant ? p1_wr : p0_wr;
  assign w_timeout = (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:    if (w_req_any) w_next = w_gnt_wr ? c_WR : c_RD;
      c_RD:      if (mem_available || w_timeout) w_next = c_RESP;
      c_WR:      w_next = c_WR_WAIT;
      c_WR_WAIT: if (mem_write_done || w_timeout) w_next = c_RESP;
      c_RESP:    w_next = c_IDLE;
      default:   w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_wr     <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= 8'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdata0 <= 32'd0;
      r_rdata1 <= 32'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_req_any) begin
            r_owner <= w_grant;
            r_wr    <= w_gnt_wr;
            r_addr  <= w_grant ? p1_addr : p0_addr;
            r_wdata <= w_grant ? p1_wdata : p0_wdata;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
          end
        end
        c_RD: begin
          if (mem_available) begin
            if (r_owner) r_rdata1 <= mem_data_out;
            else         r_rdata0 <= mem_data_out;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        c_WR_WAIT: begin
          if (!mem_write_done) begin
            if (w_timeout) r_err <= 1'b1;
            else           r_cnt <= r_cnt + 8'd1;
          end
        end
        c_RESP:  r_last <= r_owner;
        default: ;
      endcase
    end
  end

  // Memory strobes and handshakes come only from the registered state.
  always_comb begin
    mem_rd  = (r_state == c_RD);
    mem_wr  = (r_state == c_WR);
    busy    = (r_state != c_IDLE);
    p0_done = (r_state == c_RESP) && !r_owner;
    p1_done = (r_state == c_RESP) &&  r_owner;
    p0_err  = p0_done && r_err;
    p1_err  = p1_done && r_err;
  end

  assign mem_addr    = r_addr;
  assign mem_data_in = r_wdata;
  assign owner       = r_owner;
  assign p0_rdata    = r_rdata0;
  assign p1_rdata    = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_arbiter: randomized scoreboard bench for mem_arbiter        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mem_arbiter;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req   [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        p0_done, p0_err, p1_done, p1_err, busy, owner;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_wr, mem_rd, mem_write_done, mem_available;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(req[0]), .p0_wr(wr[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
    .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(req[1]), .p1_wr(wr[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
    .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_data_out(mem_data_out), .mem_write_done(mem_write_done),
    .mem_available(mem_available), .busy(busy), .owner(owner)
  );

  function automatic logic [31:0] init_word(input logic [7:0] i);
    return (i == 8'h10) ? 32'hDEADBEEF : (32'hC0DE0000 | {24'd0, i});
  endfunction

  // Memory environment: configurable response delays plus a forced-stall override.
  logic [31:0] mem_arr [0:255];
  logic [255:0] written = '0;
  int   rd_delay, wr_delay;
  int   rd_cnt = 0, wd_cnt = 0;
  logic pend_wr = 1'b0;
  logic force_na;

  assign mem_data_out   = written[mem_addr[7:0]] ? mem_arr[mem_addr[7:0]] : init_word(mem_addr[7:0]);
  assign mem_available  = mem_rd && (rd_cnt >= rd_delay) && !force_na;
  assign mem_write_done = pend_wr && (wd_cnt >= wr_delay) && !force_na;

  always @(posedge clk) begin
    if (mem_rd && !mem_available) rd_cnt <= rd_cnt + 1;
    else                          rd_cnt <= 0;
    if (mem_wr) begin
      mem_arr[mem_addr[7:0]] <= mem_data_in;
      written[mem_addr[7:0]] <= 1'b1;
      pend_wr <= 1'b1;
      wd_cnt  <= 0;
    end else if (!busy || mem_write_done) begin
      pend_wr <= 1'b0;
    end else if (pend_wr) begin
      wd_cnt <= wd_cnt + 1;
    end
  end

  // Reference model: memory image, per-port read-data holding registers, last winner.
  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] ref_mem [0:255];
  logic [31:0] last_rd [2];
  logic        model_last;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic predict(input logic p, input logic is_wr, input logic [31:0] a,
                         input logic [31:0] d, input logic frc);
    exp_t e;
    e.port = p;
    e.err  = frc;
    if (is_wr) begin
      ref_mem[a[7:0]] = d;
    end else if (!frc) begin
      last_rd[p] = ref_mem[a[7:0]];
    end
    e.rdata = last_rd[p];
    exp_q.push_back(e);
    model_last = p;
  endtask

  // Monitor: every completion pops the next expected response.
  always @(negedge clk) begin
    if (rst_n && (p0_done || p1_done)) begin
      exp_t e;
      logic p;
      p = p1_done;
      check("single_done", {31'd0, p0_done & p1_done}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: port %0d completed, expected no completion", p);
      end else begin
        e = exp_q.pop_front();
        check("done_port", {31'd0, p}, {31'd0, e.port});
        check("done_err", {31'd0, p ? p1_err : p0_err}, {31'd0, e.err});
        check("rdata", p ? p1_rdata : p0_rdata, e.rdata);
      end
    end
  end

  task automatic run_round(input logic u0, input logic u1, input logic w0, input logic w1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1, input logic frc);
    logic        use_p [2];
    logic        w_p   [2];
    logic [31:0] a_p   [2];
    logic [31:0] d_p   [2];
    logic        drop  [2];
    logic        first, single;
    int          k, remaining, rd_cycles, wr_cycles, lat_exp;
    use_p = '{u0, u1};
    w_p   = '{w0, w1};
    a_p   = '{a0, a1};
    d_p   = '{d0, d1};
    drop  = '{1'b0, 1'b0};
    single = !(u0 && u1);
    first  = single ? u1 : ~model_last;
    predict(first, w_p[first], a_p[first], d_p[first], frc);
    if (!single) predict(~first, w_p[~first], a_p[~first], d_p[~first], 1'b0);
    force_na = frc;
    for (int p = 0; p < 2; p++) begin
      if (use_p[p]) begin
        req[p] = 1'b1; wr[p] = w_p[p]; addr[p] = a_p[p]; wdata[p] = d_p[p];
      end
    end
    k = 0; rd_cycles = 0; wr_cycles = 0;
    remaining = int'(u0) + int'(u1);
    while (remaining > 0 && k < 200) begin
      @(negedge clk);
      k++;
      if (mem_rd) rd_cycles++;
      if (mem_wr) wr_cycles++;
      if (single && k == 2) begin
        addr[first] = $urandom; wdata[first] = $urandom; wr[first] = ~wr[first];
      end
      for (int p = 0; p < 2; p++) begin
        if (req[p] && (p == 0 ? p0_done : p1_done)) begin
          drop[p] = 1'b1;
          remaining--;
        end
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (drop[p]) begin req[p] = 1'b0; drop[p] = 1'b0; end
      end
    end
    if (remaining > 0) begin
      checks++;
      errors++;
      $display("FAIL round_timeout: %0d ports still waiting after %0d cycles", remaining, k);
      req[0] = 1'b0; req[1] = 1'b0;
    end else if (single) begin
      if (frc) lat_exp = TIMEOUT + 1 + int'(w_p[first]);
      else     lat_exp = w_p[first] ? 3 + wr_delay : 2 + rd_delay;
      check("latency", 32'(k - 1), 32'(lat_exp));
      check("mem_wr_cycles", 32'(wr_cycles), w_p[first] ? 32'd1 : 32'd0);
      check("mem_rd_cycles", 32'(rd_cycles),
            w_p[first] ? 32'd0 : (frc ? 32'(TIMEOUT) : 32'(1 + rd_delay)));
    end
    force_na = 1'b0;
  endtask

  task automatic run_continuous(input int n, input logic [31:0] a0, input logic [31:0] a1);
    int seen, k;
    for (int i = 0; i < n; i++) begin
      logic p;
      p = ~model_last;
      predict(p, 1'b0, p ? a1 : a0, 32'd0, 1'b0);
    end
    req = '{1'b1, 1'b1}; wr = '{1'b0, 1'b0}; addr = '{a0, a1};
    seen = 0; k = 0;
    while (seen < n && k < 400) begin
      @(negedge clk);
      k++;
      if (p0_done || p1_done) seen++;
      @(posedge clk);
      #1;
    end
    req = '{1'b0, 1'b0};
    check("continuous_count", 32'(seen), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; force_na = 1'b0; rd_delay = 0; wr_delay = 0;
    req = '{1'b0, 1'b0}; wr = '{1'b0, 1'b0};
    addr = '{32'd0, 32'd0}; wdata = '{32'd0, 32'd0};
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    last_rd = '{32'd0, 32'd0};
    model_last = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_data_in", mem_data_in, 32'd0);
    check("rst_done", {30'd0, p1_done, p0_done}, 32'd0);
    check("rst_err", {30'd0, p1_err, p0_err}, 32'd0);
    check("rst_p0_rdata", p0_rdata, 32'd0);
    check("rst_p1_rdata", p1_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_round(1, 0, 0, 0, 32'h10, 0, 0, 0, 0);
    run_round(0, 1, 0, 1, 0, 32'h20, 0, 32'h12345678, 0);
    run_round(0, 1, 0, 0, 0, 32'h20, 0, 0, 0);
    run_continuous(8, 32'h10, 32'h20);

    run_round(0, 1, 0, 0, 0, 32'h30, 0, 0, 1);
    run_round(0, 1, 0, 0, 0, 32'h10, 0, 0, 0);
    run_round(1, 0, 1, 0, 32'h34, 0, 32'h55AA55AA, 0, 1);
    run_round(1, 0, 0, 0, 32'h34, 0, 0, 0, 0);

    run_round(1, 0, 1, 0, 32'h40, 0, 32'hCAFEF00D, 0, 0);
    run_round(0, 1, 0, 0, 0, 32'h40, 0, 0, 0);

    // Reset in WR_WAIT: the write is committed but never completes.
    wr_delay = 8;
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h44; wdata[0] = 32'hFEEDFACE;
    repeat (2) begin @(negedge clk); @(posedge clk); end
    @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("arst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("arst_done", {30'd0, p1_done, p0_done}, 32'd0);
    req[0] = 1'b0;
    ref_mem[8'h44] = 32'hFEEDFACE;
    last_rd = '{32'd0, 32'd0};
    model_last = 1'b1;
    wr_delay = 0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_p0_rdata", p0_rdata, 32'd0);
    check("arst_p1_rdata", p1_rdata, 32'd0);
    run_round(1, 1, 0, 0, 32'h44, 32'h10, 0, 0, 0);

    for (int r = 0; r < 80; r++) begin
      logic u0, u1, f;
      int sel;
      sel = $urandom_range(0, 2);
      u0 = (sel != 1);
      u1 = (sel != 0);
      f  = (sel != 2) && ($urandom_range(0, 7) == 0);
      rd_delay = $urandom_range(0, 2);
      wr_delay = $urandom_range(0, 2);
      run_round(u0, u1, 1'($urandom), 1'($urandom),
                {24'd0, 8'($urandom_range(0, 63))}, {24'd0, 8'($urandom_range(0, 63))},
                $urandom, $urandom, f);
    end

    repeat (4) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
